// File: rtl/exception_entry_sequencer_if.sv
// -----------------------------------------------------------------------------
// exception_entry_sequencer_if
// Purpose : Bundles the request/status handshake and the register-bank access
//           port of the exception entry/return sequencer.
// Signals :
//   exc_req / exc_type    entry request and exception type (0..4 valid)
//   ret_req / ret_bank    return request and bank to return from
//   busy / done / masked  sequencer status (done is a one-cycle pulse)
//   rb_write_enable/index/data   bank write port (driven by the sequencer)
//   rb_read_index / rb_read_data bank read port (data is combinational)
// Modports:
//   master : the sequencer side
//   slave  : the control logic / register bank side
// -----------------------------------------------------------------------------
interface exception_entry_sequencer_if;
    logic        exc_req;
    logic [2:0]  exc_type;
    logic        ret_req;
    logic [1:0]  ret_bank;
    logic        busy;
    logic        done;
    logic        masked;
    logic        rb_write_enable;
    logic [4:0]  rb_write_index;
    logic [31:0] rb_write_data;
    logic [4:0]  rb_read_index;
    logic [31:0] rb_read_data;

    modport master (
        input  exc_req, exc_type, ret_req, ret_bank, rb_read_data,
        output busy, done, masked,
               rb_write_enable, rb_write_index, rb_write_data, rb_read_index
    );

    modport slave (
        output exc_req, exc_type, ret_req, ret_bank, rb_read_data,
        input  busy, done, masked,
               rb_write_enable, rb_write_index, rb_write_data, rb_read_index
    );
endinterface

// File: rtl/exception_entry_sequencer.sv
// -----------------------------------------------------------------------------
// exception_entry_sequencer
// Purpose : Multi-cycle initiator performing ARM exception entry (save CPSR to
//           SPSR, write banked LR, write new CPSR, jump to vector) and exception
//           return (restore CPSR from SPSR, LR -> PC) through the register
//           bank's write port and one read port.
// Ports   :
//   clk    clock
//   reset  synchronous active-high reset; aborts any sequence in progress
//   bus    exception_entry_sequencer_if.master (requests, status, bank port)
// Parameter:
//   VECTOR_BASE  base address added to each vector offset
// Build option:
//   EXC_IRQ_MASK_EN  when defined, an IRQ entry whose CPSR has I=1 finishes
//                    immediately with no writes and masked=1 alongside done.
// Bank map: PC=15, CPSR=16, {r13,r14,spsr} at 17+3*bank
//           (bank 0=SVC, 1=ABT, 2=IRQ, 3=UND).
// -----------------------------------------------------------------------------
module exception_entry_sequencer #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               reset,
    exception_entry_sequencer_if.master        bus
);

    localparam logic [4:0] IDX_PC   = 5'd15;
    localparam logic [4:0] IDX_CPSR = 5'd16;

    localparam logic [2:0] T_UND  = 3'd0;
    localparam logic [2:0] T_SVC  = 3'd1;
    localparam logic [2:0] T_PABT = 3'd2;
    localparam logic [2:0] T_DABT = 3'd3;
    localparam logic [2:0] T_IRQ  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_CPSR, S_RD_PC, S_WR_SPSR, S_WR_LR, S_WR_CPSR_E, S_WR_PC_E,
        S_RD_SPSR, S_RD_LR, S_WR_CPSR_R, S_WR_PC_R, S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_type;
    logic [1:0]  r_bank;
    logic [31:0] r_cpsr_q;
    logic [31:0] r_pc_q;
    logic [31:0] r_spsr_q;
    logic [31:0] r_lr_q;
    logic        r_done;
    logic        r_masked;
    logic        r_we;
    logic [4:0]  r_wi;
    logic [31:0] r_wd;
    logic [4:0]  r_ri;

    logic        w_type_valid;
    logic [1:0]  w_exc_bank;

    function automatic logic [4:0] r14_idx(input logic [1:0] b);
        case (b)
            2'd0:    r14_idx = 5'd18;
            2'd1:    r14_idx = 5'd21;
            2'd2:    r14_idx = 5'd24;
            default: r14_idx = 5'd27;
        endcase
    endfunction

    function automatic logic [4:0] spsr_idx(input logic [1:0] b);
        case (b)
            2'd0:    spsr_idx = 5'd19;
            2'd1:    spsr_idx = 5'd22;
            2'd2:    spsr_idx = 5'd25;
            default: spsr_idx = 5'd28;
        endcase
    endfunction

    function automatic logic [4:0] mode_code(input logic [1:0] b);
        case (b)
            2'd0:    mode_code = 5'b10011;
            2'd1:    mode_code = 5'b10111;
            2'd2:    mode_code = 5'b10010;
            default: mode_code = 5'b11011;
        endcase
    endfunction

    function automatic logic [7:0] vec_offset(input logic [2:0] t);
        case (t)
            T_UND:   vec_offset = 8'h04;
            T_SVC:   vec_offset = 8'h08;
            T_PABT:  vec_offset = 8'h0C;
            T_DABT:  vec_offset = 8'h10;
            default: vec_offset = 8'h18;
        endcase
    endfunction

    // Exception type to register bank; both abort flavours share ABT.
    always_comb begin
        w_exc_bank = 2'd0;
        case (bus.exc_type)
            T_UND:   w_exc_bank = 2'd3;
            T_SVC:   w_exc_bank = 2'd0;
            T_PABT:  w_exc_bank = 2'd1;
            T_DABT:  w_exc_bank = 2'd1;
            default: w_exc_bank = 2'd2;
        endcase
    end

    assign w_type_valid = (bus.exc_type <= T_IRQ);

    // Outputs are registered alongside the state: each transition loads the
    // port values that belong to the state being entered, so they are a pure
    // function of the current state (plus latched operands).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_type   <= 3'd0;
            r_bank   <= 2'd0;
            r_cpsr_q <= 32'd0;
            r_pc_q   <= 32'd0;
            r_spsr_q <= 32'd0;
            r_lr_q   <= 32'd0;
            r_done   <= 1'b0;
            r_masked <= 1'b0;
            r_we     <= 1'b0;
            r_wi     <= 5'd0;
            r_wd     <= 32'd0;
            r_ri     <= 5'd0;
        end else begin
            r_done   <= 1'b0;
            r_masked <= 1'b0;
            r_we     <= 1'b0;
            r_wi     <= 5'd0;
            r_wd     <= 32'd0;
            r_ri     <= 5'd0;
            case (r_state)
                S_IDLE: begin
                    if (bus.exc_req && w_type_valid) begin
                        r_type  <= bus.exc_type;
                        r_bank  <= w_exc_bank;
                        r_ri    <= IDX_CPSR;
                        r_state <= S_RD_CPSR;
                    end else if (bus.ret_req) begin
                        r_bank  <= bus.ret_bank;
                        r_ri    <= spsr_idx(bus.ret_bank);
                        r_state <= S_RD_SPSR;
                    end
                end
                S_RD_CPSR: begin
                    r_cpsr_q <= bus.rb_read_data;
`ifdef EXC_IRQ_MASK_EN
                    // IRQs already disabled: finish without touching the bank.
                    if (r_type == T_IRQ && bus.rb_read_data[7]) begin
                        r_done   <= 1'b1;
                        r_masked <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_ri    <= IDX_PC;
                        r_state <= S_RD_PC;
                    end
`else
                    r_ri    <= IDX_PC;
                    r_state <= S_RD_PC;
`endif
                end
                S_RD_PC: begin
                    r_pc_q  <= bus.rb_read_data;
                    r_we    <= 1'b1;
                    r_wi    <= spsr_idx(r_bank);
                    r_wd    <= r_cpsr_q;
                    r_state <= S_WR_SPSR;
                end
                S_WR_SPSR: begin
                    r_we    <= 1'b1;
                    r_wi    <= r14_idx(r_bank);
                    r_wd    <= (r_type == T_DABT) ? r_pc_q : (r_pc_q - 32'd4);
                    r_state <= S_WR_LR;
                end
                S_WR_LR: begin
                    // Keep flags and F, set I, clear T, switch mode.
                    r_we    <= 1'b1;
                    r_wi    <= IDX_CPSR;
                    r_wd    <= {r_cpsr_q[31:8], 1'b1, r_cpsr_q[6], 1'b0, mode_code(r_bank)};
                    r_state <= S_WR_CPSR_E;
                end
                S_WR_CPSR_E: begin
                    r_we    <= 1'b1;
                    r_wi    <= IDX_PC;
                    r_wd    <= VECTOR_BASE + {24'd0, vec_offset(r_type)};
                    r_state <= S_WR_PC_E;
                end
                S_WR_PC_E: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_RD_SPSR: begin
                    r_spsr_q <= bus.rb_read_data;
                    r_ri     <= r14_idx(r_bank);
                    r_state  <= S_RD_LR;
                end
                S_RD_LR: begin
                    r_lr_q  <= bus.rb_read_data;
                    r_we    <= 1'b1;
                    r_wi    <= IDX_CPSR;
                    r_wd    <= r_spsr_q;
                    r_state <= S_WR_CPSR_R;
                end
                S_WR_CPSR_R: begin
                    r_we    <= 1'b1;
                    r_wi    <= IDX_PC;
                    r_wd    <= r_lr_q;
                    r_state <= S_WR_PC_R;
                end
                S_WR_PC_R: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = (r_state != S_IDLE);
    assign bus.done            = r_done;
    assign bus.masked          = r_masked;
    assign bus.rb_write_enable = r_we;
    assign bus.rb_write_index  = r_wi;
    assign bus.rb_write_data   = r_wd;
    assign bus.rb_read_index   = r_ri;

endmodule

// File: tb/tb_exception_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exception_entry_sequencer
// Directed bench for exception_entry_sequencer: a small register-bank model
// answers reads combinationally and absorbs writes; each transaction's write
// log, done cycle and masked flag are compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_exception_entry_sequencer;

    logic clk;
    logic reset;
    exception_entry_sequencer_if bus ();

    exception_entry_sequencer #(.VECTOR_BASE(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] bank_mem [0:31];
    assign bus.rb_read_data = bank_mem[bus.rb_read_index];

    int          n_cmp;
    int          n_err;
    int          wlog_idx [$];
    logic [31:0] wlog_dat [$];
    int          rlog_idx [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int n, input int idx, input logic [31:0] dat);
        int          oi;
        logic [31:0] od;
        oi = (wlog_idx.size() > n) ? wlog_idx[n] : -1;
        od = (wlog_dat.size() > n) ? wlog_dat[n] : 32'hXXXX_XXXX;
        check_val({tag, "_idx"}, oi, idx);
        check_val({tag, "_dat"}, od, dat);
    endtask

    // Present a request before an edge; the edge that follows is acceptance.
    task automatic start_req(input logic e, input logic [2:0] t, input logic r,
                             input logic [1:0] b, input bit hold);
        wlog_idx.delete();
        wlog_dat.delete();
        rlog_idx.delete();
        @(negedge clk);
        bus.exc_req  = e;
        bus.exc_type = t;
        bus.ret_req  = r;
        bus.ret_bank = b;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.exc_req = 1'b0;
            bus.ret_req = 1'b0;
        end
    endtask

    // Samples mid-cycle; c-th negedge lies in cycle c after acceptance.
    task automatic wait_done(input int max_c, output int cyc, output logic msk);
        cyc = -1;
        msk = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            rlog_idx.push_back(int'(bus.rb_read_index));
            if (bus.rb_write_enable) begin
                wlog_idx.push_back(int'(bus.rb_write_index));
                wlog_dat.push_back(bus.rb_write_data);
                bank_mem[bus.rb_write_index] = bus.rb_write_data;
            end
            if (bus.done) begin
                cyc = c;
                msk = bus.masked;
                break;
            end
        end
    endtask

    initial begin
        int   cyc;
        logic msk;
        int   cnt;

        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) bank_mem[i] = 32'd0;
        bus.exc_req  = 1'b0;
        bus.exc_type = 3'd0;
        bus.ret_req  = 1'b0;
        bus.ret_bank = 2'd0;

        // Reset then idle
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_we", bus.rb_write_enable, 0);
        check_val("rst_widx", bus.rb_write_index, 0);
        check_val("rst_wdat", bus.rb_write_data, 0);
        check_val("rst_ridx", bus.rb_read_index, 0);
        check_val("rst_masked", bus.masked, 0);
        $display("txn reset: busy=%0b done=%0b we=%0b", bus.busy, bus.done, bus.rb_write_enable);

        // SVC entry
        bank_mem[16] = 32'h6000_0010;
        bank_mem[15] = 32'h0000_1008;
        start_req(1'b1, 3'd1, 1'b0, 2'd0, 1'b0);
        wait_done(12, cyc, msk);
        check_val("svc_done_cyc", cyc, 7);
        check_val("svc_nwr", wlog_idx.size(), 4);
        check_val("svc_rd1", rlog_idx[0], 16);
        check_val("svc_rd2", rlog_idx[1], 15);
        check_val("svc_rd3", rlog_idx[2], 0);
        check_wr("svc_w0", 0, 19, 32'h6000_0010);
        check_wr("svc_w1", 1, 18, 32'h0000_1004);
        check_wr("svc_w2", 2, 16, 32'h6000_0093);
        check_wr("svc_w3", 3, 15, 32'h0000_0008);
        $display("txn svc entry: done_cyc=%0d writes=%0d", cyc, wlog_idx.size());

        // DABT entry: LR is the faulting PC itself
        bank_mem[16] = 32'h0000_0010;
        bank_mem[15] = 32'h0000_2000;
        start_req(1'b1, 3'd3, 1'b0, 2'd0, 1'b0);
        wait_done(12, cyc, msk);
        check_val("dabt_done_cyc", cyc, 7);
        check_wr("dabt_w0", 0, 22, 32'h0000_0010);
        check_wr("dabt_w1", 1, 21, 32'h0000_2000);
        check_wr("dabt_w2", 2, 16, 32'h0000_0097);
        check_wr("dabt_w3", 3, 15, 32'h0000_0010);
        $display("txn dabt entry: done_cyc=%0d writes=%0d", cyc, wlog_idx.size());

        // Return from IRQ bank
        bank_mem[25] = 32'h2000_0010;
        bank_mem[24] = 32'h0000_3000;
        start_req(1'b0, 3'd0, 1'b1, 2'd2, 1'b0);
        wait_done(12, cyc, msk);
        check_val("ret_done_cyc", cyc, 5);
        check_val("ret_nwr", wlog_idx.size(), 2);
        check_val("ret_rd1", rlog_idx[0], 25);
        check_val("ret_rd2", rlog_idx[1], 24);
        check_wr("ret_w0", 0, 16, 32'h2000_0010);
        check_wr("ret_w1", 1, 15, 32'h0000_3000);
        $display("txn irq return: done_cyc=%0d writes=%0d", cyc, wlog_idx.size());

        // Both requests, UND wins; PC=0 wraps LR; F bit preserved
        bank_mem[16] = 32'h8000_0050;
        bank_mem[15] = 32'h0000_0000;
        start_req(1'b1, 3'd0, 1'b1, 2'd2, 1'b0);
        wait_done(12, cyc, msk);
        check_val("und_done_cyc", cyc, 7);
        check_wr("und_w0", 0, 28, 32'h8000_0050);
        check_wr("und_w1", 1, 27, 32'hFFFF_FFFC);
        check_wr("und_w2", 2, 16, 32'h8000_00DB);
        check_wr("und_w3", 3, 15, 32'h0000_0004);
        $display("txn und entry (both req): done_cyc=%0d writes=%0d", cyc, wlog_idx.size());

        // exc_req held through a sequence: second accepted only after DONE
        bank_mem[16] = 32'h0000_0010;
        bank_mem[15] = 32'h0000_0100;
        start_req(1'b1, 3'd1, 1'b0, 2'd0, 1'b1);
        wait_done(12, cyc, msk);
        check_val("hold_done_cyc1", cyc, 7);
        check_val("hold_nwr1", wlog_idx.size(), 4);
        @(negedge clk);
        check_val("hold_idle_after_done", bus.busy, 0);
        @(posedge clk);
        #1 bus.exc_req = 1'b0;
        wait_done(12, cyc, msk);
        check_val("hold_done_cyc2", cyc, 7);
        check_val("hold_nwr2", wlog_idx.size(), 8);
        $display("txn held svc entry: second done_cyc=%0d total writes=%0d", cyc, wlog_idx.size());

        // Invalid type ignored
        @(negedge clk);
        bus.exc_req  = 1'b1;
        bus.exc_type = 3'd7;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy || bus.rb_write_enable || bus.done) cnt++;
        end
        bus.exc_req = 1'b0;
        check_val("inv_type_activity", cnt, 0);
        $display("txn invalid type: active cycles=%0d", cnt);

        // IRQ entry with I already set
        bank_mem[16] = 32'h0000_0093;
        bank_mem[15] = 32'h0000_4000;
        start_req(1'b1, 3'd4, 1'b0, 2'd0, 1'b0);
        wait_done(12, cyc, msk);
`ifdef EXC_IRQ_MASK_EN
        check_val("irqm_done_cyc", cyc, 2);
        check_val("irqm_masked", msk, 1);
        check_val("irqm_nwr", wlog_idx.size(), 0);
`else
        check_val("irq_done_cyc", cyc, 7);
        check_val("irq_masked", msk, 0);
        check_val("irq_nwr", wlog_idx.size(), 4);
        check_wr("irq_w0", 0, 25, 32'h0000_0093);
        check_wr("irq_w1", 1, 24, 32'h0000_3FFC);
        check_wr("irq_w2", 2, 16, 32'h0000_0092);
        check_wr("irq_w3", 3, 15, 32'h0000_0018);
`endif
        $display("txn irq entry I=1: done_cyc=%0d masked=%0b writes=%0d", cyc, msk, wlog_idx.size());

        // Reset during WR_LR aborts the remaining writes
        bank_mem[16] = 32'h0000_0010;
        bank_mem[15] = 32'h0000_1008;
        start_req(1'b1, 3'd1, 1'b0, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("abort_wrlr_we", bus.rb_write_enable, 1);
        check_val("abort_wrlr_idx", bus.rb_write_index, 18);
        reset = 1'b1;
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rb_write_enable) cnt++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rb_write_enable || bus.busy || bus.done) cnt++;
        end
        check_val("abort_no_writes", cnt, 0);
        $display("txn reset in WR_LR: later activity=%0d", cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exception_entry_sequencer.md
Name: exception_entry_sequencer

Overview:
- Multi-cycle initiator that drives the register bank's write port and one read port to perform ARM exception entry and exception return.
- On entry it saves CPSR to the mode's SPSR, writes the banked LR, writes the new CPSR, then writes the vector address into PC.
- On return it restores CPSR from the banked SPSR and writes LR into PC.
- Sits between the exception/control logic and the register bank, and owns the bank write port while busy. The port mux is outside this block.

Parameters:
- VECTOR_BASE, 32'h0000_0000, base address added to each vector offset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- exc_req  input  1  exception entry request, sampled in IDLE
- exc_type  input  3  0=UND, 1=SVC, 2=PABT, 3=DABT, 4=IRQ; others invalid
- ret_req  input  1  exception return request, sampled in IDLE
- ret_bank  input  2  bank to return from: 0=SVC, 1=ABT, 2=IRQ, 3=UND
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse in DONE
- masked  output  1  valid with done; high if IRQ entry was suppressed
- rb_write_enable  output  1  bank write strobe
- rb_write_index  output  5  bank write index
- rb_write_data  output  32  bank write data
- rb_read_index  output  5  bank read index
- rb_read_data  input  32  bank combinational read data for rb_read_index

Behaviour:
- Bank map:
  - PC = 15, CPSR = 16.
  - SVC: r13/r14/spsr = 17/18/19.
  - ABT: 20/21/22.
  - IRQ: 23/24/25.
  - UND: 26/27/28.
  - PABT and DABT both use the ABT bank.
- Outputs are Moore-decoded from state. Each write happens at the clock edge that ends its state. rb_read_data is captured at the edge that ends each RD state.
- Reset: state=IDLE; busy, done, masked and rb_write_enable = 0; all indices and data = 0; internal latches = 0. Reset mid-sequence aborts immediately; no further writes occur.
- IDLE:
  - exc_req=1 with a valid exc_type: latch type, go to RD_CPSR.
  - Otherwise ret_req=1: latch ret_bank, go to RD_SPSR.
  - exc_req takes priority when both are asserted.
  - exc_req with an invalid type is ignored and the block stays in IDLE.
  - Requests are ignored while busy; they are level-sampled only in IDLE.
- Entry sequence (7 cycles, done in cycle 7 after acceptance):
  - RD_CPSR: read 16, latch cpsr_q.
  - RD_PC: read 15, latch pc_q.
  - WR_SPSR: write cpsr_q to the bank's spsr index.
  - WR_LR: write lr to the bank's r14 index.
    - lr = pc_q for DABT.
    - lr = pc_q - 4 for all other types.
    - 32-bit modulo arithmetic; pc_q=0 gives 32'hFFFF_FFFC.
  - WR_CPSR: write {cpsr_q[31:8], 1'b1 (I), cpsr_q[6] (F), 1'b0 (T), mode[4:0]}.
    - Mode codes: SVC 10011, ABT 10111, IRQ 10010, UND 11011.
  - WR_PC: write VECTOR_BASE + offset.
    - Offsets: UND 0x04, SVC 0x08, PABT 0x0C, DABT 0x10, IRQ 0x18.
  - DONE: done=1, then go to IDLE.
- Return sequence (5 cycles):
  - RD_SPSR: read the bank's spsr index, latch spsr_q.
  - RD_LR: read the bank's r14 index, latch lr_q.
  - WR_CPSR: write spsr_q to 16.
  - WR_PC: write lr_q to 15.
  - DONE: done=1, then go to IDLE.
- rb_write_enable is high only in WR_* states, exactly one cycle each.
- rb_read_index is 0 outside RD_* states.
- A new request may be accepted in the cycle after DONE.

Optional Feature:
- Macro: EXC_IRQ_MASK_EN.
- Defined: an IRQ entry whose latched cpsr_q[7]=1 goes from RD_CPSR directly to DONE. No writes are performed, and masked=1 during done.
- Undefined: IRQ entry always runs the full sequence and masked is tied to 0.

Test Plan:
- Reset, then idle for 3 cycles -> busy=0, done=0, rb_write_enable=0, all indices 0.
- SVC entry with bank CPSR=0x6000_0010 and PC=0x0000_1008 -> write sequence:
  - 19 <- 0x6000_0010
  - 18 <- 0x0000_1004
  - 16 <- 0x6000_0093
  - 15 <- 0x0000_0008
  - done in cycle 7.
- DABT entry with PC=0x0000_2000 -> 22 <- CPSR, 21 <- 0x0000_2000, 16 mode=10111 with I=1, 15 <- VECTOR_BASE+0x10.
- Return with ret_bank=2, spsr_irq=0x2000_0010, r14_irq=0x0000_3000 -> 16 <- 0x2000_0010, 15 <- 0x0000_3000, done in cycle 5.
- exc_req and ret_req both asserted with exc_type=UND -> the entry sequence runs. A second exc_req held while busy is accepted only after DONE. exc_type=7 produces no response.
- IRQ entry with CPSR bit 7 set, built with EXC_IRQ_MASK_EN -> zero writes, done and masked high in cycle 2. Without the macro, the full sequence runs and masked stays 0. Reset asserted in WR_LR -> no WR_CPSR or WR_PC writes occur.
